// File: rtl/pipe_stage_buf_if.sv
// Handshake bundle for one pipeline-stage boundary: upstream valid/ready/data,
// downstream valid/ready/data, plus flush and occupancy.
interface pipe_stage_buf_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             flush;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [1:0]       occupancy;

    // Driver side: the producer/consumer pair surrounding the stage register.
    modport master (
        output in_valid, in_data, flush, out_ready,
        input  in_ready, out_valid, out_data, occupancy
    );

    // The stage register itself.
    modport slave (
        input  in_valid, in_data, flush, out_ready,
        output in_ready, out_valid, out_data, occupancy
    );
endinterface

// File: rtl/pipe_stage_buf.sv
// Pipeline-stage register with valid/ready flow control, synchronous flush,
// bubble insertion and an optional two-entry skid buffer.
module pipe_stage_buf #(
    parameter int               WIDTH  = 32,
    parameter int               SKID   = 1,
    parameter logic [WIDTH-1:0] BUBBLE = '0
) (
    input logic           clk,
    input logic           reset,
    pipe_stage_buf_if.slave bus
);

    // Bit 0 is main_valid and bit 1 is skid_valid, so both valids and the
    // registered in_ready come straight off the state flops.
    typedef enum logic [1:0] {
        EMPTY   = 2'b00,
        FULL    = 2'b01,
        SKIDDED = 2'b11
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] main_q, main_d;
    logic [WIDTH-1:0] skid_q, skid_d;
    logic             main_valid, skid_valid;
    logic             in_fire, out_fire;

    assign main_valid = state_q[0];
    assign skid_valid = state_q[1];

    // With SKID=1 in_ready is a pure flop output; with SKID=0 it looks through to out_ready.
    assign bus.in_ready  = (SKID != 0) ? !skid_valid : (!main_valid || bus.out_ready);
    assign bus.out_valid = main_valid;
    assign bus.out_data  = main_valid ? main_q : BUBBLE;
    assign bus.occupancy = {1'b0, main_valid} + {1'b0, skid_valid};

    assign in_fire  = bus.in_valid && bus.in_ready;
    assign out_fire = main_valid && bus.out_ready;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;

        unique case (state_q)
            EMPTY: begin
                if (in_fire) begin
                    state_d = FULL;
                    main_d  = bus.in_data;
                end
            end
            FULL: begin
                if (out_fire && in_fire) begin
                    main_d = bus.in_data;
                end else if (out_fire) begin
                    state_d = EMPTY;
                end else if (in_fire && (SKID != 0)) begin
                    state_d = SKIDDED;
                    skid_d  = bus.in_data;
                end
            end
            SKIDDED: begin
                if (out_fire) begin
                    state_d = FULL;
                    main_d  = skid_q;
                end
            end
            default: state_d = EMPTY;
        endcase

        // A beat accepted in the flush cycle is swallowed here; out_fire already counted.
        if (bus.flush) begin
            state_d = EMPTY;
            main_d  = BUBBLE;
            skid_d  = BUBBLE;
        end
    end

    // NOTE: the data registers are reset too, so out_data and held payloads are a known NOP after reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            // NOTE: sequential state uses non-blocking assignments so all flops update together.
            state_q <= EMPTY;
            main_q  <= BUBBLE;
            skid_q  <= BUBBLE;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

endmodule
